uart_rx: RTL and testbench

Asynchronous serial receiver: the receive half of the team's UART, and the counterpart to the existing transmitter. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the external RXD line, running on the 12 MHz system clock. Each received byte is presented on a parallel output with a one-cycle strobe. A frame with a bad stop bit is reported as a framing error instead of a byte.

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, 3-sample majority voting at mid-bit,
// one-cycle rx_ready / rx_frame_error strobes, and break handling after a bad stop bit.
module uart_rx #(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BIT_CYCLES  = (CLK_HZ + BAUD_RATE/2) / BAUD_RATE,
  parameter int HALF_CYCLES = BIT_CYCLES/2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  logic          sync1_q, sync2_q;
  logic [1:0]    hist_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;

  logic rx_s;
  logic sample;
  logic cnt_zero;

  assign rx_s     = sync2_q;
  // Majority of the current synchronized value and the two before it.
  assign sample   = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sample) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = BIT_LOAD;
          bit_idx_d = 3'd0;
        end
      end

      ST_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {sample, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sample) begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          state_d   = ST_IDLE;
          cnt_d     = '0;
          rx_data_d = shift_q;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          state_d = ST_BREAK;
          cnt_d   = BIT_LOAD;
          ferr_d  = 1'b1;
        end
      end

      ST_BREAK: begin
        if (!rx_s) begin
          cnt_d = BIT_LOAD;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 2'b11;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_line;
      sync2_q   <= sync1_q;
      hist_q    <= {hist_q[0], sync2_q};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_ready       = ready_q;
  assign rx_frame_error = ferr_q;
  assign rx_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table, hand-written corner sequences and a randomized
// frame stream checked against an arithmetic timing/scoreboard model.
module tb_uart_rx;

  localparam int LAT = 991;  // rx_line fall to strobe, in cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_frame_error;
  logic       rx_busy;

  uart_rx dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_line        (rx_line),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_frame_error (rx_frame_error),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
  } ev_t;

  ev_t ready_q[$];
  int  ferr_q[$];
  int  excl_bad = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_ready) ready_q.push_back('{t: cyc, d: rx_data});
      if (rx_frame_error) ferr_q.push_back(cyc);
      if (rx_ready && rx_frame_error) excl_bad++;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_assert++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Line level c cycles after the start-bit fall, for a frame of p cycles/bit.
  function automatic logic line_val(input logic [7:0] b, input int p, input bit stop, input int c);
    int k;
    k = c / p;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return stop;
  endfunction

  int fall;

  task automatic drive_frame(input logic [7:0] b, input int p, input bit stop, input int glitch);
    for (int c = 0; c < 10*p; c++) begin
      @(posedge clk);
      #1;
      rx_line = (c == glitch) ? 1'b0 : line_val(b, p, stop, c);
      if (c == 0) fall = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_line = 1'b1;
    end
  endtask

  task automatic clear_events();
    ready_q.delete();
    ferr_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    int         bit_cyc;
    bit         stop;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  ev_t  exp_q[$];
  int   exp_ferr[$];

  initial begin
    int f;
    int rel;

    vecs[0] = '{8'h2E, 104, 1'b1, 1, 0, 8'h2E};
    vecs[1] = '{8'h00, 104, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 104, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5,  99, 1'b1, 1, 0, 8'hA5};
    vecs[4] = '{8'hA5, 109, 1'b1, 1, 0, 8'hA5};
    vecs[5] = '{8'h81, 104, 1'b0, 0, 1, 8'hA5};
    vecs[6] = '{8'h3C, 104, 1'b1, 1, 0, 8'h3C};

    // Reset state
    #2 reset_n = 1'b0;
    #3;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_ready", int'(rx_ready), 0);
    check("reset_rx_frame_error", int'(rx_frame_error), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(20);

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      clear_events();
      drive_frame(vecs[i].data, vecs[i].bit_cyc, vecs[i].stop, -1);
      idle(150);
      check($sformatf("vec%0d_ready_count", i), ready_q.size(), vecs[i].exp_ready);
      check($sformatf("vec%0d_ferr_count", i), ferr_q.size(), vecs[i].exp_ferr);
      check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy_idle", i), int'(rx_busy), 0);
      if (ready_q.size() > 0)
        check_near($sformatf("vec%0d_ready_latency", i), ready_q[0].t - fall, LAT, 1);
      if (ferr_q.size() > 0)
        check_near($sformatf("vec%0d_ferr_latency", i), ferr_q[0] - fall, LAT, 1);
      $display("vec%0d: byte 0x%0h at %0d cyc/bit, stop=%0d -> ready=%0d ferr=%0d rx_data=0x%0h",
               i, vecs[i].data, vecs[i].bit_cyc, vecs[i].stop, ready_q.size(), ferr_q.size(), rx_data);
    end

    // Back-to-back 0x55, 0xAA
    clear_events();
    drive_frame(8'h55, 104, 1'b1, -1);
    f = fall;
    drive_frame(8'hAA, 104, 1'b1, -1);
    idle(1100);
    check("b2b_ready_count", ready_q.size(), 2);
    if (ready_q.size() == 2) begin
      check("b2b_first_data", int'(ready_q[0].d), 8'h55);
      check("b2b_second_data", int'(ready_q[1].d), 8'hAA);
      check("b2b_spacing", ready_q[1].t - ready_q[0].t, 1040);
      check_near("b2b_first_latency", ready_q[0].t - f, LAT, 1);
    end
    $display("back-to-back: %0d strobes", ready_q.size());

    // 20-cycle low glitch on the idle line
    clear_events();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      rx_line = (c < 20) ? 1'b0 : 1'b1;
      if (c == 0) f = cyc;
      if (c == 10) check("glitch20_busy_high", int'(rx_busy), 1);
      if (c == 56) check("glitch20_busy_low", int'(rx_busy), 0);
    end
    check("glitch20_ready_count", ready_q.size(), 0);
    check("glitch20_ferr_count", ferr_q.size(), 0);
    $display("glitch20: ready=%0d ferr=%0d", ready_q.size(), ferr_q.size());

    // 1-cycle low pulse at the sample point of data bit 3
    clear_events();
    drive_frame(8'hFF, 104, 1'b1, 4*104 + 51);
    idle(150);
    check("glitch1_ready_count", ready_q.size(), 1);
    check("glitch1_rx_data", int'(rx_data), 8'hFF);
    $display("glitch1: rx_data=0x%0h", rx_data);

    // Break: line held low 2000 cycles
    clear_events();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      rx_line = 1'b0;
      if (c == 0) f = cyc;
    end
    check("break_ferr_count", ferr_q.size(), 1);
    check("break_ready_count", ready_q.size(), 0);
    check("break_rx_data_held", int'(rx_data), 8'hFF);
    check("break_busy_during", int'(rx_busy), 1);
    if (ferr_q.size() > 0) check_near("break_ferr_latency", ferr_q[0] - f, LAT, 1);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      rx_line = 1'b1;
      if (c == 0) rel = cyc;
      if (c == 100) check("break_busy_after_release", int'(rx_busy), 1);
      if (c == 110) check("break_busy_cleared", int'(rx_busy), 0);
    end
    clear_events();
    drive_frame(8'h41, 104, 1'b1, -1);
    idle(150);
    check("break_next_ready_count", ready_q.size(), 1);
    check("break_next_rx_data", int'(rx_data), 8'h41);
    $display("break: released at cycle %0d, next byte 0x%0h", rel, rx_data);

    // Reset during data bit 4 of 0xFF
    clear_events();
    for (int c = 0; c < 5*104 + 20; c++) begin
      @(posedge clk);
      #1;
      rx_line = line_val(8'hFF, 104, 1'b1, c);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    rx_line = 1'b1;
    #1;
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_rx_ready", int'(rx_ready), 0);
    check("midreset_rx_frame_error", int'(rx_frame_error), 0);
    check("midreset_rx_busy", int'(rx_busy), 0);
    idle(5);
    reset_n = 1'b1;
    idle(1200);
    check("midreset_no_strobe", ready_q.size() + ferr_q.size(), 0);
    drive_frame(8'h3C, 104, 1'b1, -1);
    idle(150);
    check("midreset_next_ready_count", ready_q.size(), 1);
    check("midreset_next_rx_data", int'(rx_data), 8'h3C);
    $display("reset mid-frame: next byte 0x%0h", rx_data);

    // Randomized frame stream against the scoreboard model
    clear_events();
    exp_q.delete();
    exp_ferr.delete();
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      int p;
      bit stop;
      b    = 8'($urandom_range(0, 255));
      p    = $urandom_range(100, 108);
      stop = ($urandom_range(0, 4) != 0);
      drive_frame(b, p, stop, -1);
      if (stop) exp_q.push_back('{t: fall + LAT, d: b});
      else      exp_ferr.push_back(fall + LAT);
      $display("rand%0d: byte 0x%0h at %0d cyc/bit, stop=%0d", k, b, p, stop);
      idle(stop ? $urandom_range(0, 30) : $urandom_range(120, 200));
    end
    idle(1100);
    check("rand_ready_count", ready_q.size(), exp_q.size());
    check("rand_ferr_count", ferr_q.size(), exp_ferr.size());
    for (int i = 0; i < exp_q.size() && i < ready_q.size(); i++) begin
      check($sformatf("rand_data%0d", i), int'(ready_q[i].d), int'(exp_q[i].d));
      check_near($sformatf("rand_time%0d", i), ready_q[i].t, exp_q[i].t, 1);
    end
    for (int i = 0; i < exp_ferr.size() && i < ferr_q.size(); i++)
      check_near($sformatf("rand_ferr_time%0d", i), ferr_q[i], exp_ferr[i], 1);

    check("strobe_exclusive", excl_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
